// File: rtl/data_mem_responder_pkg.sv
// mem_pkg: shared definitions for data_mem_responder.
//   state_t    - responder FSM state encoding
//   BYTE_LANES - bytes per data word
//   WAIT_CNT_W - width of the wait-state counter
package mem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        XFER = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int BYTE_LANES = 4;
    localparam int WAIT_CNT_W = 4;
endpackage

// File: rtl/data_mem_responder_wait_counter.sv
// wait_counter: loadable down-counter used to time the wait states.
//   i_clk, i_rst_n - clock, async active-low reset
//   i_load         - load i_load_val (has priority over i_dec)
//   i_load_val     - value to load
//   i_dec          - decrement by one (holds at zero)
//   o_last         - high while count == 1
module wait_counter
    import mem_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [WAIT_CNT_W-1:0] i_load_val,
    input  logic                  i_dec,
    output logic                  o_last
);
    logic [WAIT_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_last = (r_cnt == WAIT_CNT_W'(1));
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder for the CPU data-memory strobe interface.
// Serves one access at a time after WAIT_CYCLES wait states and pulses
// ready for one cycle. Byte-addressed, big-endian 32-bit words, addresses
// wrap modulo 2^ADDR_WIDTH.
//   CLK, RST         - clock, async active-low reset
//   nRD, nWR         - active-low read / write strobes
//   address          - byte address (bits [1:0] dropped for the word access)
//   writeData        - store data
//   Dataout          - load data, changes only on a completed read
//   ready            - one-cycle completion pulse
//   busy             - high while not IDLE
//   err              - misaligned access flag (pulses with ready)
// Optional build macro: MEM_ALIGN_CHECK_EN enables the misalignment check;
// without it low address bits are ignored and err is tied low.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        nRD,
    input  logic        nWR,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] Dataout,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:2] r_waddr;
    logic [31:0]           r_wd;
    logic                  r_op_rd;
    logic                  r_mis;
    logic                  r_ready, r_busy, r_err;
    logic [31:0]           r_dout;
    logic [7:0]            r_mem [DEPTH];

    logic                  w_start, w_last, w_misalign;
    logic [31:0]           w_rd_word;

    // Bits outside the addressed window are deliberately dropped.
    logic w_unused_addr;
    assign w_unused_addr = ^{address[31:ADDR_WIDTH], address[1:0]};

    // Exactly one strobe low starts an access; both low is ignored.
    assign w_start = (r_state == IDLE) && (nRD ^ nWR);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = r_mis;
    assign err        = r_err;
`else
    assign w_misalign = 1'b0;
    assign err        = 1'b0;
`endif

    wait_counter u_wait_counter (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_load     (w_start),
        .i_load_val (WAIT_CNT_W'(WAIT_CYCLES)),
        .i_dec      (r_state == WAIT),
        .o_last     (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_next = (WAIT_CYCLES == 0) ? XFER : WAIT;
            WAIT: if (w_last)  w_next = XFER;
            XFER: w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Big-endian assembly: lowest byte address is the MSB.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < BYTE_LANES; k++)
            w_rd_word[31-8*k -: 8] = r_mem[{r_waddr, 2'(k)}];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_waddr <= '0;
            r_wd    <= '0;
            r_op_rd <= 1'b0;
            r_mis   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == DONE);
            r_busy  <= (w_next != IDLE);
            r_err   <= 1'b0;
            if (w_start) begin
                r_waddr <= address[ADDR_WIDTH-1:2];
                r_wd    <= writeData;
                r_op_rd <= ~nRD;
                r_mis   <= |address[1:0];
            end
            if (r_state == XFER) begin
                r_err <= w_misalign;
                if (!w_misalign) begin
                    if (r_op_rd)
                        r_dout <= w_rd_word;
                    else
                        for (int k = 0; k < BYTE_LANES; k++)
                            r_mem[{r_waddr, 2'(k)}] <= r_wd[31-8*k -: 8];
                end
            end
        end
    end

    assign Dataout = r_dout;
    assign ready   = r_ready;
    assign busy    = r_busy;
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    localparam int AW = 7;
    localparam int W  = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        nRD = 1'b1;
    logic        nWR = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] Dataout;
    logic        ready, busy, err;

    data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
        .CLK(CLK), .RST(RST), .nRD(nRD), .nWR(nWR),
        .address(address), .writeData(writeData),
        .Dataout(Dataout), .ready(ready), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] dout;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_ready  = 0;
    logic [31:0] exp_dout = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (ready === 1'b1) begin
            n_ready++;
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("dout", Dataout, e.dout);
                chk("err", {31'd0, err}, {31'd0, e.err});
            end
        end
    end

    // One access. pulse=1 drives a stray nRD low through the first wait cycle.
    task automatic access(input bit rd, input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input bit pulse);
        exp_t e;
        int   lat;
        bit   seen;
        e.dout = exp_dout;
        e.err  = exp_err;
        sb.push_back(e);
        @(negedge CLK);
        nRD = ~rd; nWR = rd; address = a; writeData = wd;
        @(posedge CLK); #1;
        chk("busy_after_N", {31'd0, busy}, 32'd1);
        nWR = 1'b1;
        nRD = pulse ? 1'b0 : 1'b1;
        lat = 0; seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge CLK); #1;
            lat++;
            nRD = 1'b1;
            if (ready) seen = 1;
        end
        if (!seen) chk("ready_timeout", 32'd0, 32'd1);
        else       chk("latency", lat, W + 1);
        @(posedge CLK); #1;
    endtask

    task automatic rd_word(input logic [31:0] a, input logic [31:0] exp);
        exp_dout = exp;
        access(1'b1, a, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
        access(1'b0, a, d, 1'b0, 1'b0);
    endtask

    initial begin
        int r0;
        bit quiet;
        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_dout", Dataout, 32'h0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        rd_word(32'h00, 32'h0000_0000);

        // Basic write/read
        wr_word(32'h08, 32'h1234_5678);
        rd_word(32'h08, 32'h1234_5678);
`ifndef MEM_ALIGN_CHECK_EN
        rd_word(32'h09, 32'h1234_5678);
        rd_word(32'h0B, 32'h1234_5678);
`endif

        // Wrap-around: 0x80 aliases 0x00
        wr_word(32'h80, 32'hCAFE_BABE);
        rd_word(32'h00, 32'hCAFE_BABE);
        rd_word(32'hFFFF_FF08, 32'h1234_5678);

        // Both strobes low in IDLE: ignored
        r0 = n_ready;
        quiet = 1;
        @(negedge CLK);
        nRD = 1'b0; nWR = 1'b0; address = 32'h08; writeData = 32'hFFFF_FFFF;
        repeat (10) begin
            @(negedge CLK);
            if (busy) quiet = 0;
        end
        nRD = 1'b1; nWR = 1'b1;
        chk("both_low_ready", n_ready - r0, 32'd0);
        chk("both_low_busy", {31'd0, quiet}, 32'd1);
        rd_word(32'h08, 32'h1234_5678);

        // Stray strobe during WAIT: only the write completes
        r0 = n_ready;
        access(1'b0, 32'h20, 32'h55AA_33CC, 1'b0, 1'b1);
        repeat (6) @(negedge CLK);
        chk("wait_strobe_ready", n_ready - r0, 32'd1);
        rd_word(32'h20, 32'h55AA_33CC);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned write: err with ready, memory untouched
        access(1'b0, 32'h0A, 32'hFFFF_FFFF, 1'b1, 1'b0);
        rd_word(32'h08, 32'h1234_5678);
        access(1'b1, 32'h09, 32'h0, 1'b1, 1'b0);
`endif

        // Reset during WAIT of a write: aborted, memory cleared
        @(negedge CLK);
        nWR = 1'b0; address = 32'h10; writeData = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        nWR = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, ready}, 32'd0);
        chk("midrst_dout", Dataout, 32'h0);
        exp_dout = 32'h0;
        @(negedge CLK);
        RST = 1'b1;
        repeat (W + 4) @(negedge CLK);
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        rd_word(32'h10, 32'h0000_0000);
        rd_word(32'h08, 32'h0000_0000);

        repeat (4) @(negedge CLK);
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
